// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N LED decoder with three-pin enable and direct, running-light,
// blink and latch modes. led and pos are updated together on the same clock edge.
module decoder_scan_n #(
    parameter int SEL_W      = 3,
    parameter int TICK_DIV   = 10_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              enable,
    input  logic [1:0]              mode,
    input  logic                    dir,
    input  logic                    strobe,
    input  logic [SEL_W-1:0]        switch,
    output logic [(1<<SEL_W)-1:0]   led,
    output logic [SEL_W-1:0]        pos
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_LATCH  = 2'b11
    } mode_t;

    logic [OUT_W-1:0] led_reg, led_next;
    logic [SEL_W-1:0] pos_reg, pos_next;
    logic [CNT_W-1:0] tick_cnt_reg, tick_cnt_next;
    logic             phase_reg, phase_next;
    mode_t            mode_q_reg;

    logic             en;
    logic             entry;
    logic             tick;
    mode_t            mode_cur;
    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] led_idle;
    logic [OUT_W-1:0] led_active;

    assign en       = enable[2] & ~enable[1] & ~enable[0];
    assign mode_cur = mode_t'(mode);
    assign entry    = (mode_cur != mode_q_reg);
    assign tick     = en && !entry && (tick_cnt_reg == CNT_W'(TICK_DIV - 1));

    // Decode is taken from the next position so led and pos always agree.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
        assign onehot[gi] = (pos_next == SEL_W'(gi));
    end

    assign led_idle   = {OUT_W{ACTIVE_LOW}};
    assign led_active = onehot ^ {OUT_W{ACTIVE_LOW}};

    always_comb begin
        pos_next      = pos_reg;
        phase_next    = phase_reg;
        tick_cnt_next = tick_cnt_reg;
        led_next      = led_idle;

        if (!en) begin
            tick_cnt_next = '0;
            phase_next    = 1'b1;
        end else if (entry) begin
            tick_cnt_next = '0;
            phase_next    = 1'b1;
            if (mode_cur != MODE_LATCH) begin
                pos_next = switch;
            end
        end else begin
            tick_cnt_next = tick ? '0 : tick_cnt_reg + CNT_W'(1);
            case (mode_cur)
                MODE_DIRECT: pos_next = switch;
                MODE_SCAN: begin
                    if (tick) begin
                        pos_next = dir ? pos_reg - SEL_W'(1) : pos_reg + SEL_W'(1);
                    end
                end
                MODE_BLINK: begin
                    pos_next = switch;
                    if (tick) begin
                        phase_next = ~phase_reg;
                    end
                end
                MODE_LATCH: begin
                    if (strobe) begin
                        pos_next = switch;
                    end
                end
                default: pos_next = pos_reg;
            endcase
        end

        if (en && !(mode_cur == MODE_BLINK && !phase_next)) begin
            led_next = led_active;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_reg      <= {OUT_W{ACTIVE_LOW}};
            pos_reg      <= '0;
            tick_cnt_reg <= '0;
            phase_reg    <= 1'b1;
            mode_q_reg   <= MODE_DIRECT;
        end else begin
            led_reg      <= led_next;
            pos_reg      <= pos_next;
            tick_cnt_reg <= tick_cnt_next;
            phase_reg    <= phase_next;
            mode_q_reg   <= mode_cur;
        end
    end

    assign led = led_reg;
    assign pos = pos_reg;

endmodule
